// File: rtl/uart_resp_framer.sv
// Captures one bus response per host transaction and serialises it as a
// checksummed byte frame toward the UART transmitter.
module uart_resp_framer #(
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        gnt_i,
   input  logic        we_i,
   input  logic        valid_i,
   input  logic [31:0] rdata_i,
   input  logic        err_i,
   input  logic        intg_err_i,
   output logic        tx_valid_o,
   output logic [7:0]  tx_data_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic        drop_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RSP = 2'd1,
      SEND     = 2'd2
   } state_e;

   localparam logic [15:0] CntLast = 16'(TimeoutCycles - 1);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  status_q, status_d;
   logic [7:0]  chk_q, chk_d;
   logic [3:0]  idx_q, idx_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        drop_q, drop_d;

   logic        capture_s;
   logic        cap_we_s;
   logic [7:0]  cap_status_s;
   logic [31:0] cap_rdata_s;
   logic [3:0]  last_idx_s;

   // Checksum covers VER, STATUS, RSV and (reads only) the four data bytes.
   function automatic logic [7:0] calc_chk(input logic we, input logic [7:0] status,
                                           input logic [31:0] rdata);
      logic [7:0] c;
      c = 8'h01 ^ status ^ 8'h00;
      if (!we) begin
         c = c ^ rdata[7:0] ^ rdata[15:8] ^ rdata[23:16] ^ rdata[31:24];
      end else begin
         c = c;
      end
      return c;
   endfunction

   function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic we,
                                             input logic [7:0] status, input logic [31:0] rdata,
                                             input logic [7:0] chk);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'h5A;
         4'd1:    b = 8'h01;
         4'd2:    b = status;
         4'd3:    b = 8'h00;
         4'd4:    b = we ? chk : rdata[7:0];
         4'd5:    b = rdata[15:8];
         4'd6:    b = rdata[23:16];
         4'd7:    b = rdata[31:24];
         4'd8:    b = chk;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign last_idx_s = we_q ? 4'd4 : 4'd8;

   // Next-state, capture and transmit-sequencing logic.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      status_d     = status_q;
      chk_d        = chk_q;
      idx_d        = idx_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      drop_d       = 1'b0;
      capture_s    = 1'b0;
      cap_we_s     = we_q;
      cap_status_s = 8'h00;
      cap_rdata_s  = 32'h0000_0000;

      case (state_q)
         IDLE: begin
            if (req_i && gnt_i) begin
               we_d  = we_i;
               cnt_d = 16'd0;
               if (valid_i) begin
                  capture_s    = 1'b1;
                  cap_we_s     = we_i;
                  cap_status_s = {4'b0000, we_i, 1'b0, intg_err_i, err_i};
                  cap_rdata_s  = rdata_i;
               end else begin
                  state_d = WAIT_RSP;
               end
            end else if (valid_i) begin
               drop_d = 1'b1;
            end else begin
               drop_d = 1'b0;
            end
         end
         WAIT_RSP: begin
            cnt_d = cnt_q + 16'd1;
            // A response arriving on the final count still wins over the timeout.
            if (valid_i) begin
               capture_s    = 1'b1;
               cap_status_s = {4'b0000, we_q, 1'b0, intg_err_i, err_i};
               cap_rdata_s  = rdata_i;
            end else if (cnt_q == CntLast) begin
               capture_s    = 1'b1;
               cap_status_s = {4'b0000, we_q, 1'b1, 1'b0, 1'b0};
               cap_rdata_s  = 32'h0000_0000;
            end else begin
               capture_s = 1'b0;
            end
            if (req_i && gnt_i) begin
               drop_d = 1'b1;
            end else begin
               drop_d = 1'b0;
            end
         end
         SEND: begin
            if ((req_i && gnt_i) || valid_i) begin
               drop_d = 1'b1;
            end else begin
               drop_d = 1'b0;
            end
            if (tx_valid_q && tx_ready_i) begin
               if (idx_q == last_idx_s) begin
                  state_d    = IDLE;
                  idx_d      = 4'd0;
                  tx_valid_d = 1'b0;
                  tx_data_d  = 8'h00;
               end else begin
                  idx_d     = idx_q + 4'd1;
                  tx_data_d = frame_byte(idx_q + 4'd1, we_q, status_q, rdata_q, chk_q);
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase

      if (capture_s) begin
         state_d    = SEND;
         we_d       = cap_we_s;
         status_d   = cap_status_s;
         rdata_d    = cap_rdata_s;
         chk_d      = calc_chk(cap_we_s, cap_status_s, cap_rdata_s);
         idx_d      = 4'd0;
         tx_valid_d = 1'b1;
         tx_data_d  = 8'h5A;
      end else begin
         chk_d = chk_d;
      end
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         cnt_q      <= 16'd0;
         rdata_q    <= 32'h0000_0000;
         status_q   <= 8'h00;
         chk_q      <= 8'h00;
         idx_q      <= 4'd0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         status_q   <= status_d;
         chk_q      <= chk_d;
         idx_q      <= idx_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         drop_q     <= drop_d;
      end
   end

   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;
   assign busy_o     = (state_q != IDLE);
   assign drop_o     = drop_q;

endmodule

// File: tb/tb_uart_resp_framer.sv
// Scoreboard bench for uart_resp_framer: expected frame bytes are queued when a
// transaction is launched and popped as the DUT hands bytes to the UART.
module tb_uart_resp_framer;

   localparam int unsigned TO = 16;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        gnt_i = 1'b0;
   logic        we_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] rdata_i = 32'h0;
   logic        err_i = 1'b0;
   logic        intg_err_i = 1'b0;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i = 1'b1;
   logic        busy_o;
   logic        drop_o;

   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_q[$];
   int          acc_cnt = 0;
   int          drop_cnt = 0;
   bit          rand_ready = 1'b0;
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   logic [7:0]  exp_b;

   uart_resp_framer #(.TimeoutCycles(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_i(gnt_i), .we_i(we_i),
      .valid_i(valid_i), .rdata_i(rdata_i), .err_i(err_i), .intg_err_i(intg_err_i),
      .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
      .busy_o(busy_o), .drop_o(drop_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Byte monitor: pops the scoreboard on every accepted byte, checks stall stability.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("stall_valid", 32'(tx_valid_o), 32'd1);
            check_eq("stall_data", 32'(tx_data_o), 32'(prev_data));
         end
         if (tx_valid_o && tx_ready_i) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_extra", 32'(tx_data_o), 32'hFFFF_FFFF);
            end else begin
               exp_b = exp_q.pop_front();
               check_eq("byte", 32'(tx_data_o), 32'(exp_b));
            end
            acc_cnt++;
         end
         if (drop_o) drop_cnt++;
         prev_stall = tx_valid_o && !tx_ready_i;
         prev_data  = tx_data_o;
      end
   end

   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic push_frame(input logic we, input logic [7:0] st, input logic [31:0] d);
      logic [7:0] c;
      c = 8'h01 ^ st;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'h01);
      exp_q.push_back(st);
      exp_q.push_back(8'h00);
      if (!we) begin
         for (int i = 0; i < 4; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            c = c ^ d[8*i +: 8];
         end
      end
      exp_q.push_back(c);
   endtask

   task automatic clear_in();
      req_i = 1'b0; gnt_i = 1'b0; we_i = 1'b0; valid_i = 1'b0;
      rdata_i = 32'h0; err_i = 1'b0; intg_err_i = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((busy_o || exp_q.size() != 0) && n < 500) begin
         tick();
         n++;
      end
      check_eq("done_busy", 32'(busy_o), 32'd0);
      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // delay 0: response with grant; >0: response sampled delay edges later; <0: none.
   task automatic run_txn(input logic we, input int delay, input logic [31:0] d,
                          input logic err, input logic intg);
      int n;
      if (delay < 0) push_frame(we, {4'b0000, we, 1'b1, 2'b00}, 32'h0);
      else           push_frame(we, {4'b0000, we, 1'b0, intg, err}, d);
      req_i = 1'b1; gnt_i = 1'b1; we_i = we;
      if (delay == 0) begin
         valid_i = 1'b1; rdata_i = d; err_i = err; intg_err_i = intg;
      end
      tick();
      clear_in();
      check_eq("busy", 32'(busy_o), 32'd1);
      if (delay > 0) begin
         repeat (delay - 1) tick();
         valid_i = 1'b1; rdata_i = d; err_i = err; intg_err_i = intg;
         tick();
         clear_in();
      end
      if (delay >= 0) begin
         check_eq("lat", 32'(tx_valid_o), 32'd1);
      end else begin
         n = 0;
         while (!tx_valid_o && n < 100) begin
            tick();
            n++;
         end
         check_eq("to_lat", 32'(n), 32'(TO));
      end
      wait_done();
   endtask

   initial begin
      int d0;
      int n;
      int target;
      clear_in();
      tick();
      tick();
      check_eq("rst_valid", 32'(tx_valid_o), 32'd0);
      check_eq("rst_data", 32'(tx_data_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_drop", 32'(drop_o), 32'd0);
      rst_ni = 1'b1;
      tick();

      run_txn(1'b0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_txn(1'b1, 0, 32'h0, 1'b0, 1'b0);
      run_txn(1'b1, 0, 32'h0, 1'b1, 1'b0);
      run_txn(1'b0, -1, 32'h0, 1'b0, 1'b0);
      run_txn(1'b0, 16, 32'h1234_5678, 1'b0, 1'b0);
      run_txn(1'b0, 1, 32'hA5A5_0F0F, 1'b0, 1'b1);
      rand_ready = 1'b1;
      run_txn(1'b0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_txn(1'b1, 5, 32'h0, 1'b1, 1'b1);
      rand_ready = 1'b0;
      tick();

      d0 = drop_cnt;
      valid_i = 1'b1; rdata_i = 32'h1111_2222;
      tick();
      clear_in();
      tick();
      tick();
      check_eq("drop_idle", 32'(drop_cnt - d0), 32'd1);
      check_eq("drop_idle_busy", 32'(busy_o), 32'd0);

      rand_ready = 1'b1;
      d0 = drop_cnt;
      push_frame(1'b0, 8'h00, 32'hCAFE_F00D);
      req_i = 1'b1; gnt_i = 1'b1; valid_i = 1'b1; rdata_i = 32'hCAFE_F00D;
      tick();
      clear_in();
      tick();
      req_i = 1'b1; gnt_i = 1'b1;
      tick();
      clear_in();
      wait_done();
      check_eq("drop_send", 32'(drop_cnt - d0), 32'd1);
      rand_ready = 1'b0;
      tick();

      push_frame(1'b0, 8'h00, 32'hDEAD_BEEF);
      target = acc_cnt + 4;
      req_i = 1'b1; gnt_i = 1'b1; valid_i = 1'b1; rdata_i = 32'hDEAD_BEEF;
      tick();
      clear_in();
      n = 0;
      while (acc_cnt < target && n < 50) begin
         tick();
         n++;
      end
      check_eq("mid_bytes", 32'(acc_cnt), 32'(target));
      rst_ni = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(tx_valid_o), 32'd0);
      check_eq("mid_rst_data", 32'(tx_data_o), 32'd0);
      check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
      check_eq("mid_rst_drop", 32'(drop_o), 32'd0);
      exp_q.delete();
      tick();
      rst_ni = 1'b1;
      tick();
      run_txn(1'b0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/uart_resp_framer.md
UART_RESP_FRAMER -- requirements
Module: uart_resp_framer

Interface
REQ-001 SHALL have parameter: TimeoutCycles, default 1024, max cycles waiting for a bus response after grant (range 2..65535).
REQ-002 SHALL have ports: clk_i  input  1  clock, rising edge.
REQ-003 SHALL have ports: rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_i  input  1  host request (observed from UART host bridge).
REQ-005 SHALL have ports: gnt_i  input  1  host grant (observed).
REQ-006 SHALL have ports: we_i  input  1  host write enable (observed).
REQ-007 SHALL have ports: valid_i  input  1  response valid from adapter.
REQ-008 SHALL have ports: rdata_i  input  32  response read data.
REQ-009 SHALL have ports: err_i  input  1  bus error.
REQ-010 SHALL have ports: intg_err_i  input  1  integrity error.
REQ-011 SHALL have ports: tx_valid_o  output  1  byte available to UART TX.
REQ-012 SHALL have ports: tx_data_o  output  8  byte to UART TX.
REQ-013 SHALL have ports: tx_ready_i  input  1  UART TX accepts byte.
REQ-014 SHALL have ports: busy_o  output  1  transaction outstanding or frame being sent; bridge must not launch while high.
REQ-015 SHALL have ports: drop_o  output  1  one-cycle pulse, event discarded.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT_RSP, SEND; busy_o = (state != IDLE).
REQ-017 IDLE: on req_i && gnt_i SHALL latch we_i, clear timeout counter, go WAIT_RSP; if valid_i in the same cycle, SHALL take it as that transaction's response and go directly to SEND.
REQ-018 IDLE: valid_i without same-cycle grant SHALL pulse drop_o and be ignored.
REQ-019 WAIT_RSP: counter SHALL increment each cycle; on valid_i SHALL capture rdata_i, err_i, intg_err_i and go SEND.
REQ-020 WAIT_RSP: when counter = TimeoutCycles-1 without valid_i SHALL capture timeout status, data 0x00000000, go SEND; valid_i in that same cycle wins (no timeout).
REQ-021 Grant observed in WAIT_RSP or SEND SHALL pulse drop_o and not alter state; valid_i in SEND SHALL pulse drop_o.
REQ-022 STATUS byte SHALL be {4'b0, we, timeout, intg_err, err} (bit0 = err).
REQ-023 Frame SHALL be: SOF 0x5A, VER 0x01, STATUS, RSV 0x00, then for reads D0..D3 (rdata LSB first), then CHK; write frame = 5 bytes, read frame = 9 bytes (data sent also on error/timeout reads).
REQ-024 CHK SHALL be the XOR of all bytes from VER through last data byte (SOF excluded), computed at capture.
REQ-025 SEND: tx_valid_o SHALL be 1 and tx_data_o SHALL show the current byte from registered state; byte index SHALL advance only on tx_valid_o && tx_ready_i; tx_data_o SHALL be stable while tx_ready_i = 0.
REQ-026 After the last byte is accepted SHALL return to IDLE in the next cycle; a new grant is accepted in the first IDLE cycle.
REQ-027 First frame byte SHALL be presented the cycle after capture (capture -> tx_valid_o latency 1 cycle).

Reset
REQ-028 Asserting rst_ni low at any time, including mid-frame, SHALL force IDLE and abort the frame; partial frames are not resumed.
REQ-029 Reset values SHALL be: tx_valid_o 0, tx_data_o 0x00, busy_o 0, drop_o 0, counter 0, captured data/status 0.

Verification
REQ-030 Read, grant then valid_i after 3 cycles, rdata 0xDEADBEEF, no err, tx_ready_i=1 -> bytes 5A 01 00 00 EF BE AD DE 23, then busy_o=0.
REQ-031 Write, grant and valid_i same cycle, no err -> bytes 5A 01 08 00 09; write with err_i=1 -> 5A 01 09 00 08.
REQ-032 Read with no valid_i, TimeoutCycles=16 -> after 16 cycles in WAIT_RSP, bytes 5A 01 04 00 00 00 00 00 05; valid_i exactly at count 15 -> normal frame, no timeout bit.
REQ-033 tx_ready_i randomly deasserted during 0xDEADBEEF read frame -> same 9 bytes in order, no repeats/skips, tx_data_o stable while stalled.
REQ-034 valid_i in IDLE without grant, and grant during SEND -> one drop_o pulse each, frame in progress unaffected.
REQ-035 rst_ni low after 4th byte of a read frame -> outputs at reset values immediately; next transaction emits a complete fresh frame.
